// File: rtl/sys_result_drain.sv
// sys_result_drain: captures per-PE results on store-enable and drains them in PE-index order to the result RAM.
// Define SYS_DRAIN_SATWORD_EN to append the saturation-map word at base+NPE after slot NPE-1.
module sys_result_drain #(
    parameter int NPE = 16,
    parameter int AW  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_adr,
    input  logic [NPE-1:0]    se,
    input  logic [16*NPE-1:0] s_out_all,
    input  logic [NPE-1:0]    sat,
    output logic              res_wen,
    input  logic              res_rdy,
    output logic [AW-1:0]     res_wadr,
    output logic [15:0]       res_wdata,
    output logic              busy,
    output logic              done,
    output logic              done_irq,
    output logic              ovf,
    output logic [NPE-1:0]    sat_map
);
    localparam int PW = $clog2(NPE);

`ifdef SYS_DRAIN_SATWORD_EN
    typedef enum logic [1:0] {IDLE, COLLECT, FLAG, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
`endif

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NPE-1:0] valid_q, valid_d;
    logic [15:0]    hold_q [NPE];
    logic [15:0]    hold_d [NPE];
    logic [AW-1:0]  base_q, base_d;
    logic           ovf_q, ovf_d;
    logic [NPE-1:0] sat_map_q, sat_map_d;
    logic           done_irq_q, done_irq_d;
    logic           accept;

    always_comb begin
        res_wen   = state_q == COLLECT && valid_q[ptr_q];
        res_wadr  = base_q + AW'(ptr_q);
        res_wdata = hold_q[ptr_q];
`ifdef SYS_DRAIN_SATWORD_EN
        if (state_q == FLAG) begin
            res_wen   = 1'b1;
            res_wadr  = base_q + AW'(NPE);
            res_wdata = 16'(sat_map_q);
        end
`endif
    end

    assign accept = res_wen && res_rdy && !start;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        base_d    = base_q;
        ovf_d     = ovf_q;
        sat_map_d = sat_map_q;
        if (start) begin
            state_d   = COLLECT;
            ptr_d     = '0;
            valid_d   = '0;
            ovf_d     = 1'b0;
            sat_map_d = '0;
            base_d    = base_adr;
        end else begin
            if (state_q == COLLECT) begin
                // a strobe for a slot already holding or already drained data is an overrun
                for (int i = 0; i < NPE; i++) begin
                    if (se[i]) begin
                        if (valid_q[i] || i < int'(ptr_q)) begin
                            ovf_d = 1'b1;
                        end else begin
                            hold_d[i]    = s_out_all[16*i +: 16];
                            valid_d[i]   = 1'b1;
                            sat_map_d[i] = sat[i];
                        end
                    end
                end
                if (accept) begin
                    valid_d[ptr_q] = 1'b0;
                    ptr_d          = ptr_q + 1'b1;
`ifdef SYS_DRAIN_SATWORD_EN
                    if (ptr_q == PW'(NPE-1)) state_d = FLAG;
`else
                    if (ptr_q == PW'(NPE-1)) state_d = DONE;
`endif
                end
            end
`ifdef SYS_DRAIN_SATWORD_EN
            if (state_q == FLAG && accept) state_d = DONE;
`endif
        end
        done_irq_d = state_d == DONE && state_q != DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            valid_q    <= '0;
            base_q     <= '0;
            ovf_q      <= 1'b0;
            sat_map_q  <= '0;
            done_irq_q <= 1'b0;
            for (int i = 0; i < NPE; i++) hold_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            base_q     <= base_d;
            ovf_q      <= ovf_d;
            sat_map_q  <= sat_map_d;
            done_irq_q <= done_irq_d;
            hold_q     <= hold_d;
        end
    end

`ifdef SYS_DRAIN_SATWORD_EN
    assign busy = state_q == COLLECT || state_q == FLAG;
`else
    assign busy = state_q == COLLECT;
`endif
    assign done     = state_q == DONE;
    assign done_irq = done_irq_q;
    assign ovf      = ovf_q;
    assign sat_map  = sat_map_q;
endmodule

// File: tb/tb_sys_result_drain.sv
// tb_sys_result_drain: directed table plus multi-cycle sequences for sys_result_drain.
module tb_sys_result_drain;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [17:0]  base_adr = '0;
    logic [15:0]  se = '0;
    logic [255:0] s_out_all;
    logic [15:0]  sat = '0;
    logic         res_wen;
    logic         res_rdy = 1'b0;
    logic [17:0]  res_wadr;
    logic [15:0]  res_wdata;
    logic         busy, done, done_irq, ovf;
    logic [15:0]  sat_map;

    sys_result_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .se(se),
        .s_out_all(s_out_all), .sat(sat), .res_wen(res_wen), .res_rdy(res_rdy),
        .res_wadr(res_wadr), .res_wdata(res_wdata), .busy(busy), .done(done),
        .done_irq(done_irq), .ovf(ovf), .sat_map(sat_map)
    );

    always #5 clk = ~clk;

`ifdef SYS_DRAIN_SATWORD_EN
    localparam int NW = 17;
`else
    localparam int NW = 16;
`endif

    int ncmp = 0;
    int nerr = 0;
    logic [17:0] wa[$];
    logic [15:0] wd[$];

    // accepted writes are logged half a cycle before the edge that takes them
    always @(negedge clk)
        if (rst_n && res_wen && res_rdy && !start) begin
            wa.push_back(res_wadr);
            wd.push_back(res_wdata);
        end

    typedef struct {
        logic        st;
        logic [17:0] base;
        logic [15:0] se;
        logic [15:0] sat;
        logic        rdy;
        logic        wen;
        logic [17:0] wadr;
        logic [15:0] wdata;
        logic        busy;
        logic        done;
        logic        irq;
        logic        ovf;
    } vec_t;
    vec_t tv[20];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick(input logic r);
        logic w0, st0;
        logic [17:0] a0;
        logic [15:0] d0;
        res_rdy = r;
        w0 = res_wen; a0 = res_wadr; d0 = res_wdata; st0 = start;
        @(posedge clk);
        #1;
        if (w0 && !r && !st0) begin
            chk("hold_wen", res_wen, 1);
            chk("hold_wadr", res_wadr, a0);
            chk("hold_wdata", res_wdata, d0);
        end
    endtask

    task automatic strobe(input logic [15:0] m, input logic r);
        se = m;
        tick(r);
        se = '0;
    endtask

    task automatic do_start(input logic [17:0] b);
        start = 1'b1;
        base_adr = b;
        tick(1'b1);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic toggle, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(toggle ? (n % 2 == 0) : 1'b1);
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    initial begin
        int b, b2;
        for (int i = 0; i < 16; i++) s_out_all[16*i +: 16] = 16'h1000 + 16'(i);

        tv[0] = '{1'b1, 18'h100, 16'h0, 16'h0, 1'b1, 1'b0, 18'h100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 16; k++)
            tv[k] = '{1'b0, 18'h0, 16'(1 << (k-1)), 16'h0, 1'b1, 1'b1,
                      18'h100 + 18'(k-1), 16'h1000 + 16'(k-1), 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SYS_DRAIN_SATWORD_EN
        tv[17] = '{1'b0, 18'h0, 16'h0, 16'h0, 1'b1, 1'b1, 18'h110, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[18] = '{1'b0, 18'h0, 16'h0, 16'h0, 1'b1, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        tv[17] = '{1'b0, 18'h0, 16'h0, 16'h0, 1'b1, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[18] = '{1'b0, 18'h0, 16'h0, 16'h0, 1'b1, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
        tv[19] = '{1'b0, 18'h0, 16'h0, 16'h0, 1'b1, 1'b0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0};

        #12;
        chk("rst_wen", res_wen, 0);
        chk("rst_wadr", res_wadr, 0);
        chk("rst_wdata", res_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", done_irq, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat_map", sat_map, 0);
        @(negedge clk) rst_n = 1'b1;

        // in-order drain, one strobe per cycle, rdy tied high
        b = wa.size();
        for (int i = 0; i < 20; i++) begin
            start = tv[i].st; base_adr = tv[i].base; se = tv[i].se; sat = tv[i].sat;
            tick(tv[i].rdy);
            chk($sformatf("v%0d_wen", i), res_wen, tv[i].wen);
            if (tv[i].wen) begin
                chk($sformatf("v%0d_wadr", i), res_wadr, tv[i].wadr);
                chk($sformatf("v%0d_wdata", i), res_wdata, tv[i].wdata);
            end
            chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d_done", i), done, tv[i].done);
            chk($sformatf("v%0d_irq", i), done_irq, tv[i].irq);
            chk($sformatf("v%0d_ovf", i), ovf, tv[i].ovf);
        end
        start = 1'b0; se = '0;
        chk("inorder_count", wa.size() - b, NW);

        // reset mid-run at ptr = 7
        do_start(18'h40);
        sat = 16'h00FF;
        for (int i = 0; i < 7; i++) strobe(16'(1 << i), 1'b1);
        sat = '0;
        tick(1'b1);
        chk("pre_rst_wen", res_wen, 0);
        chk("pre_rst_wadr", res_wadr, 18'h47);
        chk("pre_rst_sat_map", sat_map, 16'h007F);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", res_wen, 0);
        chk("mid_rst_wadr", res_wadr, 0);
        chk("mid_rst_wdata", res_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sat_map", sat_map, 0);
        @(negedge clk) rst_n = 1'b1;
        b = wa.size();
        se = 16'hFFFF;
        repeat (3) tick(1'b1);
        se = '0;
        chk("idle_se_wen", res_wen, 0);
        chk("idle_se_busy", busy, 0);
        chk("idle_se_ovf", ovf, 0);
        chk("idle_se_sat_map", sat_map, 0);
        chk("idle_se_writes", wa.size() - b, 0);

        // reverse-order strobes with toggling backpressure
        do_start(18'h100);
        b = wa.size();
        for (int k = 15; k >= 0; k--) strobe(16'(1 << k), k % 2 == 0);
        wait_done(1'b1, 200);
        chk("rev_count", wa.size() - b, NW);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rev_wadr%0d", i), wa[b+i], 18'h100 + 18'(i));
            chk($sformatf("rev_wdata%0d", i), wd[b+i], 16'h1000 + 16'(i));
        end
        chk("rev_ovf", ovf, 0);

        // overrun on slot 3; the first capture must win
        do_start(18'h200);
        b = wa.size();
        strobe(16'h0008, 1'b1);
        s_out_all[63:48] = 16'hBEEF;
        strobe(16'h0008, 1'b1);
        chk("ovr_ovf", ovf, 1);
        s_out_all[63:48] = 16'h1003;
        strobe(16'h0007, 1'b1);
        strobe(16'hFFF0, 1'b1);
        wait_done(1'b0, 100);
        chk("ovr_count", wa.size() - b, NW);
        chk("ovr_wadr3", wa[b+3], 18'h203);
        chk("ovr_wdata3", wd[b+3], 16'h1003);
        chk("ovr_wdata15", wd[b+15], 16'h100F);
        chk("ovr_ovf_sticky", ovf, 1);

        // abort at ptr = 5, then a clean run with sat = 0x8001
        do_start(18'h300);
        b = wa.size();
        strobe(16'hFFFF, 1'b1);
        repeat (5) tick(1'b1);
        chk("abort_pre_writes", wa.size() - b, 5);
        chk("abort_pre_wadr", res_wadr, 18'h305);
        do_start(18'h380);
        chk("abort_writes", wa.size() - b, 5);
        chk("abort_wen", res_wen, 0);
        chk("abort_busy", busy, 1);
        b2 = wa.size();
        sat = 16'h8001;
        strobe(16'hFFFF, 1'b1);
        sat = '0;
        wait_done(1'b0, 100);
        chk("abort_run_count", wa.size() - b2, NW);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("abort_wadr%0d", i), wa[b2+i], 18'h380 + 18'(i));
            chk($sformatf("abort_wdata%0d", i), wd[b2+i], 16'h1000 + 16'(i));
        end
`ifdef SYS_DRAIN_SATWORD_EN
        chk("satword_wadr", wa[b2+16], 18'h390);
        chk("satword_wdata", wd[b2+16], 16'h8001);
`endif
        chk("abort_sat_map", sat_map, 16'h8001);
        chk("abort_ovf", ovf, 0);

        // address wrap and a strobe for an already-drained slot
        do_start(18'h3FFF8);
        b = wa.size();
        strobe(16'hFFFF, 1'b1);
        repeat (2) tick(1'b1);
        strobe(16'h0001, 1'b1);
        chk("drained_ovf", ovf, 1);
        wait_done(1'b0, 100);
        chk("wrap_count", wa.size() - b, NW);
        chk("wrap_wadr7", wa[b+7], 18'h3FFFF);
        chk("wrap_wadr8", wa[b+8], 18'h0);
        chk("wrap_wadr15", wa[b+15], 18'h7);
        chk("wrap_wdata0", wd[b], 16'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
